bcd_clock_mux_display: RTL

Parametrised successor of the team's minutes/seconds counter-plus-display block. Runs a full BCD HH:MM:SS time-of-day counter from a 1 Hz tick generated internally from clk_50Mhz. Adds run/stop and hour/minute set inputs. Drives a 4- or 6-digit multiplexed 7-segment display with a selectable view, leading-zero blanking and a blinking colon. Sits between debounced front-panel buttons and the board display pins.

---
 rtl/bcd_clock_mux_display_pkg.sv | 54 +++++
 rtl/bcd_clock_mux_display_if.sv | 28 ++
 rtl/bcd_seg_decode.sv | 21 ++
 rtl/bcd_clock_mux_display.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/bcd_clock_mux_display_pkg.sv
// Purpose: shared constants, types and BCD helpers for the time-of-day display blocks.
// Latency: n/a (package only).
// Backpressure: n/a.
package bcd_clock_mux_display_pkg;

  // Active-low {a,b,c,d,e,f,g,dp}; dp is dark (1) in every digit pattern.
  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] SEG_DIGIT [0:9] = '{
    8'b00000011, 8'b10011111, 8'b00100101, 8'b00001101, 8'b10011001,
    8'b01001001, 8'b01000001, 8'b00011111, 8'b00000001, 8'b00001001
  };

  localparam int SEC_MAX = 59;
  localparam int MIN_MAX = 59;
  localparam int HR_MAX  = 23;

  // Logical digit slots, numbered from the rightmost digit of the full HH:MM:SS string.
  typedef enum logic [2:0] {
    S1  = 3'd0,
    S10 = 3'd1,
    M1  = 3'd2,
    M10 = 3'd3,
    H1  = 3'd4,
    H10 = 3'd5
  } digit_slot_e;

  typedef struct packed {
    logic [3:0] h10;
    logic [3:0] h1;
    logic [3:0] m10;
    logic [3:0] m1;
    logic [3:0] s10;
    logic [3:0] s1;
  } time_bcd_t;

  // True when the two-digit BCD field {tens,ones} has reached its limit.
  function automatic logic bcd_at_max(input logic [7:0] v, input int max);
    return (int'(v[7:4]) * 10 + int'(v[3:0])) >= max;
  endfunction

  // Two-digit BCD increment that wraps to 00 after the limit.
  function automatic logic [7:0] bcd_inc_wrap(input logic [7:0] v, input int max);
    logic [7:0] r;
    if (bcd_at_max(v, max)) begin
      r = 8'h00;
    end else if (v[3:0] == 4'd9) begin
      r = {v[7:4] + 4'd1, 4'd0};
    end else begin
      r = {v[7:4], v[3:0] + 4'd1};
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd_clock_mux_display_if.sv
// Purpose: front-panel controls in, time and display pins out, for bcd_clock_mux_display.
// Latency: n/a (signal bundle).
// Backpressure: none; set inputs are single-cycle pulses, outputs are free-running.
// Ports: run/view_hm/set_min/set_hr (controls), time_bcd/tick_1hz (time), an/seg (display).
interface bcd_clock_mux_display_if #(
  parameter int NUM_DIGITS = 4
);
  logic                  run;
  logic                  view_hm;
  logic                  set_min;
  logic                  set_hr;
  logic [23:0]           time_bcd;
  logic                  tick_1hz;
  logic [NUM_DIGITS-1:0] an;
  logic [7:0]            seg;

  // master: the front panel / board side that drives the controls.
  modport master (
    output run, view_hm, set_min, set_hr,
    input  time_bcd, tick_1hz, an, seg
  );

  // slave: the clock/display block itself.
  modport slave (
    input  run, view_hm, set_min, set_hr,
    output time_bcd, tick_1hz, an, seg
  );
endinterface

// File: rtl/bcd_seg_decode.sv
// Purpose: BCD digit to active-low 7-segment pattern, with forced blank; dp always dark.
// Latency: combinational.
// Backpressure: none.
// Ports: bcd (4-bit digit), blank (force all segments off), seg ({a..g,dp}, active-low).
module bcd_seg_decode
  import bcd_clock_mux_display_pkg::*;
(
  input  logic [3:0] bcd,
  input  logic       blank,
  output logic [7:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    // Non-decimal codes fall through to blank rather than showing garbage.
    if (!blank && (bcd <= 4'd9)) begin
      seg = SEG_DIGIT[bcd];
    end
  end

endmodule

// File: rtl/bcd_clock_mux_display.sv
// Purpose: BCD HH:MM:SS time-of-day counter with set buttons, driving a multiplexed 7-seg display.
// Latency: time updates on the tick edge, tick_1hz/an/seg are registered one cycle after their cause.
// Backpressure: none; set pulses always take effect and override a coincident 1 Hz tick.
// Ports: clk_50Mhz, rst (async, active-high), bus (slave modport: controls in, time/display out).
module bcd_clock_mux_display
  import bcd_clock_mux_display_pkg::*;
#(
  parameter int CLK_HZ      = 50000000,
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 65536,
  parameter int BLANK_LZ    = 1
) (
  input  logic                     clk_50Mhz,
  input  logic                     rst,
  bcd_clock_mux_display_if.slave   bus
);

  localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [NUM_DIGITS-1:0] AN_ONE = {{(NUM_DIGITS-1){1'b0}}, 1'b1};

  logic [PW-1:0]         presc;
  logic                  presc_wrap;
  logic                  set_any;
  logic                  tick;
  logic                  tick_q;
  time_bcd_t             tm;
  time_bcd_t             tm_nxt;
  logic [RW-1:0]         rcnt;
  logic                  rcnt_wrap;
  logic [2:0]            idx;
  logic                  view_q;
  logic [2:0]            slot_num;
  digit_slot_e           slot;
  logic [3:0]            nib;
  logic                  blank;
  logic                  dp_lit;
  logic [7:0]            seg_raw;
  logic [NUM_DIGITS-1:0] an_q;
  logic [7:0]            seg_q;

  // ---------------------------------------------------------------- prescaler
  assign presc_wrap = bus.run && (presc == PW'(CLK_HZ - 1));
  assign set_any    = bus.set_min | bus.set_hr;
  // A set pulse swallows a coincident tick so the user sees exactly the value they set.
  assign tick       = presc_wrap && !set_any;

  always_ff @(posedge clk_50Mhz or posedge rst) begin
    if (rst) begin
      presc <= '0;
    end else if (!bus.run || bus.set_min || presc_wrap) begin
      // set_min restarts the second so the new minute starts on a full second.
      presc <= '0;
    end else begin
      presc <= presc + PW'(1);
    end
  end

  always_ff @(posedge clk_50Mhz or posedge rst) begin
    if (rst) begin
      tick_q <= 1'b0;
    end else begin
      tick_q <= tick;
    end
  end

  // ---------------------------------------------------------- time counter
  always_comb begin
    tm_nxt = tm;
    if (set_any) begin
      if (bus.set_hr) begin
        {tm_nxt.h10, tm_nxt.h1} = bcd_inc_wrap({tm.h10, tm.h1}, HR_MAX);
      end
      // Minute set never carries into hours; it clears seconds instead.
      if (bus.set_min) begin
        {tm_nxt.m10, tm_nxt.m1} = bcd_inc_wrap({tm.m10, tm.m1}, MIN_MAX);
        {tm_nxt.s10, tm_nxt.s1} = 8'h00;
      end
    end else if (tick) begin
      {tm_nxt.s10, tm_nxt.s1} = bcd_inc_wrap({tm.s10, tm.s1}, SEC_MAX);
      if (bcd_at_max({tm.s10, tm.s1}, SEC_MAX)) begin
        {tm_nxt.m10, tm_nxt.m1} = bcd_inc_wrap({tm.m10, tm.m1}, MIN_MAX);
        if (bcd_at_max({tm.m10, tm.m1}, MIN_MAX)) begin
          {tm_nxt.h10, tm_nxt.h1} = bcd_inc_wrap({tm.h10, tm.h1}, HR_MAX);
        end
      end
    end
  end

  always_ff @(posedge clk_50Mhz or posedge rst) begin
    if (rst) begin
      tm <= '0;
    end else begin
      tm <= tm_nxt;
    end
  end

  // ------------------------------------------------------------------ scan
  assign rcnt_wrap = (rcnt == RW'(REFRESH_DIV - 1));

  always_ff @(posedge clk_50Mhz or posedge rst) begin
    if (rst) begin
      rcnt   <= '0;
      idx    <= '0;
      view_q <= 1'b0;
    end else if (rcnt_wrap) begin
      rcnt   <= '0;
      idx    <= (idx == 3'(NUM_DIGITS - 1)) ? 3'd0 : idx + 3'd1;
      // View is sampled only at a scan step so a change never splits a slot.
      view_q <= bus.view_hm;
    end else begin
      rcnt   <= rcnt + RW'(1);
    end
  end

  // Map the physical digit position onto a logical time field.
  always_comb begin
    slot_num = idx;
    if ((NUM_DIGITS == 4) && view_q) begin
      slot_num = idx + 3'd2;
    end
    slot = digit_slot_e'(slot_num);
  end

  always_comb begin
    nib = 4'hF;
    case (slot)
      S1:      nib = tm.s1;
      S10:     nib = tm.s10;
      M1:      nib = tm.m1;
      M10:     nib = tm.m10;
      H1:      nib = tm.h1;
      H10:     nib = tm.h10;
      default: nib = 4'hF;
    endcase
  end

  assign blank = (BLANK_LZ != 0) && (slot == H10) && (tm.h10 == 4'd0);

  // Colon sits on physical digit 2 (and 4 in the six-digit layout); it blinks at 1 Hz while running.
  assign dp_lit = ((idx == 3'd2) || ((NUM_DIGITS == 6) && (idx == 3'd4))) &&
                  (!bus.run || (presc < PW'(CLK_HZ / 2)));

  bcd_seg_decode u_seg_decode (
    .bcd   (nib),
    .blank (blank),
    .seg   (seg_raw)
  );

  always_ff @(posedge clk_50Mhz or posedge rst) begin
    if (rst) begin
      an_q  <= '0;
      seg_q <= SEG_BLANK;
    end else begin
      an_q  <= AN_ONE << idx;
      seg_q <= {seg_raw[7:1], ~dp_lit};
    end
  end

  assign bus.time_bcd = tm;
  assign bus.tick_1hz = tick_q;
  assign bus.an       = an_q;
  assign bus.seg      = seg_q;

endmodule
